softex_out_packer: RTL and testbench
====================================

# softex_out_packer

Width-converting packer on the SoftEx store path, between the datapath result stream and the output cast/strobe stage that feeds the TCDM sink. It collects `IN_WIDTH`-bit result words into `OUT_WIDTH`-bit beats with byte strobes, tracks a programmed transfer length, and emits a partial, strobe-masked final beat. Double buffering (accumulator + output register) sustains one input word per cycle under output backpressure.

## Interface
- `IN_WIDTH`, default 32: input word width in bits; multiple of 8.
- `OUT_WIDTH`, default 256: output beat width in bits; `R = OUT_WIDTH/IN_WIDTH` is a power of two, ≥ 2.
- `LEN_WIDTH`, default 16: width of the length field.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous soft clear; same effect as `rst_i`.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `tot_len_i`  in  `LEN_WIDTH`  number of input words in the transfer; sampled with `start_i`.
- `in_valid_i` / `in_ready_o`  in/out  1  input handshake.
- `in_data_i`  in  `IN_WIDTH`  result word.
- `out_valid_o` / `out_ready_i`  out/in  1  output handshake.
- `out_data_o`  out  `OUT_WIDTH`  packed beat.
- `out_strb_o`  out  `OUT_WIDTH/8`  byte strobes.
- `busy_o`  out  1  high outside IDLE.
- `done_o`  out  1  one-cycle pulse at transfer end.

## Operation
- FSM: IDLE, PACK, DRAIN.
- IDLE: on `start_i`, latch `tot_len_i` into `remaining` and clear `idx`, `acc` and the `acc_pending` flag.
  - If `tot_len_i == 0`, stay in IDLE and pulse `done_o` on the next cycle. No beat is emitted.
  - Otherwise go to PACK.
- PACK: `in_ready_o = !acc_pending`.
- On an input handshake:
  - Write the word to `acc[idx*IN_WIDTH +: IN_WIDTH]` and set its `IN_WIDTH/8` strobe bits.
  - Increment `idx`. Decrement `remaining`.
- The beat is complete when `idx == R-1` or `remaining == 1` at the handshake. On completion:
  - If OUT is empty, or OUT is handshaking this cycle, move the beat (including the new word) into OUT. Clear `acc`, its strobes and `idx`.
  - Otherwise set `acc_pending`. The beat moves into OUT in the first cycle OUT empties or fires, and `acc_pending` clears.
- Once the final word is accepted, go to DRAIN. `in_ready_o` is 0 in DRAIN.
- DRAIN: when the last beat handshakes out of OUT and `acc_pending == 0`, go to IDLE and pulse `done_o` in that same cycle.
- Lane order: word k of a beat sits at bits `[k*IN_WIDTH +: IN_WIDTH]`. Unfilled lanes output data 0 and strobe 0.
- `start_i` outside IDLE is ignored. Words presented in IDLE are not accepted (`in_ready_o = 0`).
- `rst_i` or `clear_i`, including mid-transfer: in the next cycle all state is in IDLE and all outputs are at reset values. Buffered data is discarded.

## Timing
- Reset values: `in_ready_o`, `out_valid_o`, `busy_o`, `done_o` = 0; `out_data_o`, `out_strb_o` = 0.
- Beat-completing input handshake at cycle t → `out_valid_o` high at t+1 (when OUT is free).
- `out_data_o` and `out_strb_o` are registered. They stay stable while `out_valid_o && !out_ready_i`.
- `in_ready_o` does not depend combinationally on `in_valid_i`.
- `busy_o` rises the cycle after an accepted `start_i` (non-zero length) and falls together with the `done_o` pulse.
- Throughput: one word per cycle sustained if the output accepts one beat every R cycles.
  - With OUT stalled, at most R words plus one full beat are buffered. Then `in_ready_o` drops.
- Simultaneous OUT handshake and accumulator completion: the new beat loads OUT in the same cycle, with no bubble.

## Test plan
- R=8, `tot_len_i=16`, words 0x00..0x0F, output always ready → two beats. Beat 0 lane k = k, strb 0xFFFFFFFF; beat 1 lanes 8..15. `done_o` pulses on the 2nd beat handshake.
- `tot_len_i=20` → three beats. Last beat holds words 16..19 in lanes 0..3, strb 0x0000FFFF, lanes 4..7 data 0.
- `tot_len_i=24`, `out_ready_i` held low for 20 cycles → `in_ready_o` drops after 16 words accepted. No data lost. Order is preserved after release.
- `tot_len_i=0` with `start_i` → `done_o` one-cycle pulse, no `out_valid_o`, `busy_o` stays 0.
- `clear_i` asserted after 5 of 16 words → next cycle all outputs 0. A new `start_i` with `tot_len_i=8` yields one clean beat with no stale lanes.
- `start_i` pulsed mid-transfer with `tot_len_i=3` → ignored. The original 16-word transfer completes unchanged.

Source files
------------

// File: rtl/softex_out_packer.sv
// Width-converting packer: gathers IN_WIDTH-bit result words into OUT_WIDTH-bit
// strobed beats over a programmed transfer length. The accumulator and the output register form a double buffer.
module softex_out_packer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 256,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   tot_len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IN_WIDTH-1:0]    in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_WIDTH-1:0]   out_data_o,
  output logic [OUT_WIDTH/8-1:0] out_strb_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned R      = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned SB     = IN_WIDTH / 8;
  localparam int unsigned STRB_W = OUT_WIDTH / 8;
  localparam int unsigned IDXW   = $clog2(R);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [OUT_WIDTH-1:0]  acc_q, acc_d;
  logic [STRB_W-1:0]     acc_strb_q, acc_strb_d;
  logic                  pend_q, pend_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic [STRB_W-1:0]     out_strb_q, out_strb_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;

  logic                  in_ready;
  logic                  in_fire, out_fire, out_free;
  logic                  last_word, complete, drain_done;
  logic [OUT_WIDTH-1:0]  acc_w;
  logic [STRB_W-1:0]     strb_w;
  int unsigned           lane;

  always_comb begin
    in_ready   = (state_q == PACK) && !pend_q;
    in_fire    = in_valid_i && in_ready;
    out_fire   = out_valid_q && out_ready_i;
    out_free   = !out_valid_q || out_fire;
    last_word  = (rem_q == LEN_WIDTH'(1));
    complete   = in_fire && ((idx_q == IDXW'(R - 1)) || last_word);
    drain_done = (state_q == DRAIN) && out_fire && !pend_q;

    lane   = 32'(idx_q);
    acc_w  = acc_q;
    strb_w = acc_strb_q;
    acc_w[lane*IN_WIDTH +: IN_WIDTH] = in_data_i;
    strb_w[lane*SB +: SB]            = '1;

    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    acc_strb_d  = acc_strb_q;
    pend_d      = pend_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem_d      = tot_len_i;
          idx_d      = '0;
          acc_d      = '0;
          acc_strb_d = '0;
          pend_d     = 1'b0;
          if (tot_len_i == '0) done_d = 1'b1;
          else                 state_d = PACK;
        end
      end
      default: begin
        if (out_fire) out_valid_d = 1'b0;
        // A parked beat takes priority; in_ready is low while it waits,
        // so it never collides with a new completion.
        if (pend_q && out_free) begin
          out_data_d  = acc_q;
          out_strb_d  = acc_strb_q;
          out_valid_d = 1'b1;
          pend_d      = 1'b0;
          acc_d       = '0;
          acc_strb_d  = '0;
          idx_d       = '0;
        end else if (complete && out_free) begin
          out_data_d  = acc_w;
          out_strb_d  = strb_w;
          out_valid_d = 1'b1;
          acc_d       = '0;
          acc_strb_d  = '0;
          idx_d       = '0;
        end else if (complete) begin
          acc_d      = acc_w;
          acc_strb_d = strb_w;
          idx_d      = '0;
          pend_d     = 1'b1;
        end else if (in_fire) begin
          acc_d      = acc_w;
          acc_strb_d = strb_w;
          idx_d      = idx_q + IDXW'(1);
        end
        if (in_fire) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (last_word) state_d = DRAIN;
        end
        if (drain_done) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      acc_strb_q  <= '0;
      pend_q      <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      acc_strb_q  <= acc_strb_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q || drain_done;

endmodule

// File: tb/tb_softex_out_packer.sv
// Directed bench for softex_out_packer (32-bit words into 256-bit beats, R=8).
module tb_softex_out_packer;

  logic         clk = 1'b0;
  logic         rst, clear, start;
  logic [15:0]  tot_len;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         out_valid, out_ready;
  logic [255:0] out_data;
  logic [31:0]  out_strb;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  softex_out_packer #(.IN_WIDTH(32), .OUT_WIDTH(256), .LEN_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .tot_len_i(tot_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_strb_o(out_strb), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    int unsigned tot;
    logic [31:0] base;
    int unsigned stall;     // negedges with out_ready low after start
    int unsigned nbeats;
    logic [31:0] last_strb;
    int          drop_at;   // words accepted when in_ready first drops, -1 = never
    bit          inject;    // pulse start with tot_len=3 mid-transfer
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input int id);
    int acc_cnt = 0;
    int first_low = -1;
    int beat = 0;
    logic held = 1'b0;
    logic [255:0] hd = '0;
    @(negedge clk);
    start = 1'b1;
    tot_len = 16'(v.tot);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk($sformatf("v%0d busy_start", id), busy, 1'b1);
    fork
      begin
        for (int n = 0; acc_cnt < int'(v.tot) && n < 300; n++) begin
          in_valid = 1'b1;
          in_data  = v.base + acc_cnt;
          if (in_ready) acc_cnt++;
          else if (first_low < 0) first_low = acc_cnt;
          @(negedge clk);
          #1;
        end
        in_valid = 1'b0;
        chk($sformatf("v%0d words_accepted", id), acc_cnt, v.tot);
        chk($sformatf("v%0d ready_drop_at", id), first_low, v.drop_at);
      end
      begin
        for (int c = 0; beat < int'(v.nbeats) && c < 400; c++) begin
          out_ready = (c >= int'(v.stall));
          #1;
          if (held) chk($sformatf("v%0d stable_data", id), out_data, hd);
          held = 1'b0;
          if (out_valid && out_ready) begin
            logic [255:0] exp_d;
            logic [31:0]  exp_s;
            exp_d = '0;
            for (int k = 0; k < 8; k++) begin
              int w;
              w = beat * 8 + k;
              if (w < int'(v.tot)) exp_d[k*32 +: 32] = v.base + w;
            end
            exp_s = (beat == int'(v.nbeats) - 1) ? v.last_strb : 32'hFFFF_FFFF;
            chk($sformatf("v%0d b%0d data", id, beat), out_data, exp_d);
            chk($sformatf("v%0d b%0d strb", id, beat), out_strb, exp_s);
            chk($sformatf("v%0d b%0d done", id, beat), done, beat == int'(v.nbeats) - 1);
            beat++;
          end else if (out_valid) begin
            held = 1'b1;
            hd   = out_data;
          end
          @(negedge clk);
        end
        out_ready = 1'b1;
        chk($sformatf("v%0d beats", id), beat, v.nbeats);
      end
      begin
        if (v.inject) begin
          repeat (6) @(negedge clk);
          start   = 1'b1;
          tot_len = 16'd3;
          @(negedge clk);
          start   = 1'b0;
        end
      end
    join
    #1;
    chk($sformatf("v%0d busy_end", id), busy, 1'b0);
    chk($sformatf("v%0d done_end", id), done, 1'b0);
    chk($sformatf("v%0d valid_end", id), out_valid, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8,   32'h50,  0,  1, 32'hFFFF_FFFF, -1, 0};
    tbl[1] = '{16,  32'h0,   0,  2, 32'hFFFF_FFFF, -1, 0};
    tbl[2] = '{20,  32'h0,   0,  3, 32'h0000_FFFF, -1, 0};
    tbl[3] = '{24,  32'd100, 20, 3, 32'hFFFF_FFFF, 16, 0};
    tbl[4] = '{1,   32'hA5,  0,  1, 32'h0000_000F, -1, 0};
    tbl[5] = '{9,   32'h300, 3,  2, 32'h0000_000F, -1, 0};
    tbl[6] = '{16,  32'd200, 0,  2, 32'hFFFF_FFFF, -1, 1};

    rst = 1'b1; clear = 1'b0; start = 1'b0; tot_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst out_data", out_data, '0);
    chk("rst out_strb", out_strb, '0);

    // zero-length transfer
    @(negedge clk);
    start = 1'b1; tot_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zlen done", done, 1'b1);
    chk("zlen busy", busy, 1'b0);
    chk("zlen valid", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("zlen done_once", done, 1'b0);
    chk("zlen valid2", out_valid, 1'b0);

    // clear mid-transfer with a beat held in OUT
    @(negedge clk);
    start = 1'b1; tot_len = 16'd16; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_0000 + i;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("pre_clear valid", out_valid, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear in_ready", in_ready, 1'b0);
    chk("clear out_valid", out_valid, 1'b0);
    chk("clear busy", busy, 1'b0);
    chk("clear done", done, 1'b0);
    chk("clear out_data", out_data, '0);
    chk("clear out_strb", out_strb, '0);

    for (int i = 0; i < 7; i++) run_xfer(tbl[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
